// File: rtl/mem_arb_pkg.sv
// Shared types for the memory client arbiter: FSM states, client ids and the
// fixed-priority arbitration function.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        CLIENT_NONE = 2'd0,
        CLIENT_CPU  = 2'd1,
        CLIENT_VID  = 2'd2,
        CLIENT_REF  = 2'd3
    } client_t;

    // An overdue refresh (two or more owed) beats everyone; one owed refresh only fills idle slots.
    function automatic client_t pick_client(input logic [1:0] pending, input logic vid,
                                            input logic cpu);
        client_t result;
        if (pending >= 2'd2) begin
            result = CLIENT_REF;
        end else if (vid) begin
            result = CLIENT_VID;
        end else if (cpu) begin
            result = CLIENT_CPU;
        end else if (pending != 2'd0) begin
            result = CLIENT_REF;
        end else begin
            result = CLIENT_NONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval counter plus a 2-bit saturating count of refreshes owed to
// the memory controller.
module refresh_timer #(
    parameter int unsigned INTERVAL = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       done,
    output logic [1:0] pending
);

    localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = enable && (count == CW'(INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pending <= '0;
        end else begin
            if (enable) begin
                count <= wrap ? '0 : count + 1'b1;
            end
            // A wrap and a completion on the same edge cancel out.
            if (wrap && !done) begin
                if (pending != 2'd3) pending <= pending + 2'd1;
            end else if (done && !wrap) begin
                if (pending != 2'd0) pending <= pending - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_client_arbiter.sv
// Arbitrates CPU, video and refresh access to a single memory controller and
// returns read data to the client that was served.
module mem_client_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W           = DEFAULT_ADDR_W,
    parameter int unsigned REFRESH_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_dout,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_busy,
    output logic              ready
);

    arb_state_t state;
    client_t    served;
    client_t    winner;
    logic [1:0] pending;
    logic       cpu_write;
    logic       ref_done;

    assign ref_done = (state == WAIT_DONE) && !mem_busy && (served == CLIENT_REF);

    // The ack cycle is a turnaround slot: the finishing client may still show req.
    assign winner = (cpu_ack || vid_ack) ? CLIENT_NONE : pick_client(pending, vid_req, cpu_req);

    refresh_timer #(
        .INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (ready),
        .done   (ref_done),
        .pending(pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            served      <= CLIENT_NONE;
            cpu_write   <= 1'b0;
            ready       <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_ack     <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_dout    <= '0;
            vid_dout    <= '0;
        end else begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_ack     <= 1'b0;
            if (!mem_busy) ready <= 1'b1;

            case (state)
                IDLE: begin
                    if (!mem_busy && (winner != CLIENT_NONE)) begin
                        served <= winner;
                        state  <= WAIT_BUSY;
                        case (winner)
                            CLIENT_VID: begin
                                mem_read <= 1'b1;
                                mem_addr <= vid_addr;
                            end
                            CLIENT_CPU: begin
                                mem_read  <= !cpu_we;
                                mem_write <= cpu_we;
                                mem_addr  <= cpu_addr;
                                mem_din   <= cpu_din;
                                cpu_write <= cpu_we;
                            end
                            CLIENT_REF: mem_refresh <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                WAIT_BUSY: begin
                    if (mem_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!mem_busy) begin
                        state <= IDLE;
                        case (served)
                            CLIENT_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!cpu_write) cpu_dout <= mem_dout;
                            end
                            CLIENT_VID: begin
                                vid_ack  <= 1'b1;
                                vid_dout <= mem_dout;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_client_arbiter.sv
// Directed bench for mem_client_arbiter: a vector table of single transactions
// plus hand sequences for init, contention, refresh starvation and mid-reset.
module tb_mem_client_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        vid_req = 1'b0;
    logic [21:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_dout;
    logic        mem_read, mem_write, mem_refresh;
    logic [21:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_busy;
    logic        ready;

    logic        force_busy = 1'b1;
    logic [2:0]  bfm_cnt = 3'd0;
    logic [4:0]  bfm_addr = 5'd0;
    logic [7:0]  bmem [32] = '{0: 8'h81, 5: 8'hA5, 16: 8'h11, 23: 8'h5A, 31: 8'hC3,
                               default: 8'h00};

    int n_vec = 0;
    int n_bad = 0;
    int busy_viol = 0;
    int excl_viol = 0;
    logic busy_prev = 1'b1;

    always #5 clk = ~clk;

    mem_client_arbiter #(
        .ADDR_W          (22),
        .REFRESH_INTERVAL(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_dout   (vid_dout),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_refresh(mem_refresh),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_busy   (mem_busy),
        .ready      (ready)
    );

    // Controller model: busy for 4 cycles after a strobe, read data valid as busy falls.
    assign mem_busy = force_busy | (bfm_cnt != 3'd0);

    always @(posedge clk) begin
        if (mem_read || mem_write || mem_refresh) begin
            bfm_cnt  <= 3'd4;
            bfm_addr <= mem_addr[4:0];
            mem_dout <= 8'hEE;
            if (mem_write) bmem[mem_addr[4:0]] <= mem_din;
        end else if (bfm_cnt != 3'd0) begin
            bfm_cnt <= bfm_cnt - 3'd1;
            if (bfm_cnt == 3'd1) mem_dout <= bmem[bfm_addr];
        end
    end

    always @(negedge clk) begin
        if ((mem_read || mem_write || mem_refresh) && busy_prev) busy_viol <= busy_viol + 1;
        if ((32'(mem_read) + 32'(mem_write) + 32'(mem_refresh)) > 32'd1) excl_viol <= excl_viol + 1;
        busy_prev <= mem_busy;
    end

    typedef struct packed {
        logic        vid;
        logic        we;
        logic [21:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [51:0] all_outs();
        return {mem_read, mem_write, mem_refresh, cpu_ack, vid_ack, ready,
                mem_addr, mem_din, cpu_dout, vid_dout};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int s_cyc, a_cyc, n_str, n_ack, n_other;
        logic [21:0] s_addr;
        logic [7:0]  s_din;
        string tag;
        tag = $sformatf("vec%0d", idx);
        s_cyc = -1; a_cyc = -1; n_str = 0; n_ack = 0; n_other = 0;
        s_addr = '0; s_din = '0;
        if (v.vid) begin
            vid_addr = v.addr;
            vid_req  = 1'b1;
        end else begin
            cpu_addr = v.addr;
            cpu_din  = v.din;
            cpu_we   = v.we;
            cpu_req  = 1'b1;
        end
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (v.we ? mem_write : mem_read) begin
                n_str++;
                s_cyc  = t;
                s_addr = mem_addr;
                s_din  = mem_din;
            end
            if (v.vid ? vid_ack : cpu_ack) begin
                n_ack++;
                a_cyc = t;
            end
            if (v.vid ? cpu_ack : vid_ack) n_other++;
            // Client drops req one cycle after it sees ack.
            if (a_cyc >= 0 && t == a_cyc + 1) begin
                cpu_req = 1'b0;
                vid_req = 1'b0;
            end
            if (a_cyc >= 0 && t == a_cyc + 8) break;
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        chk({tag, "_ack_seen"}, 64'(a_cyc >= 0), 64'd1);
        chk({tag, "_strobes"}, 64'(n_str), 64'd1);
        chk({tag, "_acks"}, 64'(n_ack), 64'd1);
        chk({tag, "_other_ack"}, 64'(n_other), 64'd0);
        chk({tag, "_latency"}, 64'(a_cyc - s_cyc), 64'd6);
        chk({tag, "_addr"}, 64'(s_addr), 64'(v.addr));
        if (v.we) chk({tag, "_din"}, 64'(s_din), 64'(v.din));
        chk({tag, "_dout"}, 64'(v.vid ? vid_dout : cpu_dout), 64'(v.exp));
    endtask

    initial begin
        int n, r, s, pprev, pafter, got, nvb, vs, cs, vac, cac, nva, nca, nrd;
        logic [21:0] first_addr;

        //             vid  we    addr          din    exp
        vecs[0] = '{1'b0, 1'b0, 22'h012345, 8'h00, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 22'h000010, 8'h3C, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 22'h000010, 8'h00, 8'h3C};
        vecs[3] = '{1'b1, 1'b0, 22'h000777, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 1'b0, 22'h3FFFFF, 8'h00, 8'hC3};
        vecs[5] = '{1'b0, 1'b1, 22'h3FFFFF, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 22'h3FFFFF, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 22'h000000, 8'h00, 8'h81};

        // Controller initialising: busy held high for 100 cycles after reset.
        force_busy = 1'b1;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        reset = 1'b0;
        vid_addr = 22'h000777;
        vid_req  = 1'b1;
        n = 0; r = 0;
        repeat (100) begin
            @(negedge clk);
            if (mem_read || mem_write || mem_refresh) n++;
            if (ready) r++;
        end
        chk("init_no_strobe", 64'(n), 64'd0);
        chk("init_ready_low", 64'(r), 64'd0);
        vid_req    = 1'b0;
        force_busy = 1'b0;
        @(negedge clk);
        chk("init_ready_rise", 64'(ready), 64'd1);
        chk("init_no_ack", 64'({cpu_ack, vid_ack}), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Simultaneous CPU and video requests.
        do_reset();
        cpu_we = 1'b0; cpu_addr = 22'h012345; cpu_req = 1'b1;
        vid_addr = 22'h000777; vid_req = 1'b1;
        vs = -1; cs = -1; vac = -1; cac = -1; nva = 0; nca = 0; nrd = 0; first_addr = '1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (mem_read) begin
                nrd++;
                if (nrd == 1) first_addr = mem_addr;
                if (mem_addr == 22'h012345) cs = t;
                if (mem_addr == 22'h000777) vs = t;
            end
            if (vid_ack) begin nva++; vac = t; end
            if (cpu_ack) begin nca++; cac = t; end
            if (vac >= 0 && t == vac + 1) vid_req = 1'b0;
            if (cac >= 0 && t == cac + 1) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        chk("both_first_is_video", 64'(first_addr), 64'h000777);
        chk("both_vid_acks", 64'(nva), 64'd1);
        chk("both_cpu_acks", 64'(nca), 64'd1);
        chk("both_read_strobes", 64'(nrd), 64'd2);
        chk("both_cpu_after_vid_ack", 64'((cs - vac >= 1) && (cs - vac <= 2) && vs >= 0), 64'd1);
        chk("both_vid_dout", 64'(vid_dout), 64'h5A);
        chk("both_cpu_dout", 64'(cpu_dout), 64'hA5);

        // Continuous video traffic must not starve refresh forever.
        do_reset();
        vid_addr = 22'h000777; vid_req = 1'b1;
        s = -1; pprev = 0; pafter = 3; got = 0; nvb = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s < 0 && mem_refresh) begin s = t; got = pprev; end
            if (s < 0 && vid_ack) nvb++;
            if (s >= 0 && t == s + 6) begin
                pafter = int'(dut.u_refresh_timer.pending);
                break;
            end
            pprev = int'(dut.u_refresh_timer.pending);
        end
        vid_req = 1'b0;
        chk("ref_seen", 64'(s >= 0), 64'd1);
        chk("ref_pending_before", 64'(got), 64'd2);
        chk("ref_pending_after", 64'(pafter), 64'd1);
        chk("ref_video_served_first", 64'(nvb >= 2), 64'd1);

        // Reset while the controller is finishing a CPU read.
        do_reset();
        cpu_we = 1'b0; cpu_addr = 22'h012345; cpu_req = 1'b1;
        s = -1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (mem_read) begin s = t; break; end
        end
        chk("mid_strobe_seen", 64'(s >= 0), 64'd1);
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", 64'(all_outs()), 64'd0);
        reset = 1'b0;
        n = 0; r = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) n++;
            if (mem_read || mem_write || mem_refresh) r++;
        end
        chk("mid_no_ack", 64'(n), 64'd0);
        chk("mid_no_strobe", 64'(r), 64'd0);

        chk("busy_guard", 64'(busy_viol), 64'd0);
        chk("strobe_exclusive", 64'(excl_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_client_arbiter.md
MEM_CLIENT_ARBITER -- requirements
Module: mem_client_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, memory word address width.
REQ-002 SHALL have parameter REFRESH_INTERVAL, default 1024, clk cycles between refresh requests.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_we, input, 1/1: CPU request level and write select (1=write, 0=read).
REQ-006 SHALL have ports cpu_addr/cpu_din, input, ADDR_W/8: CPU address and write data.
REQ-007 SHALL have ports cpu_ack/cpu_dout, output, 1/8: one-cycle completion pulse and read data.
REQ-008 SHALL have ports vid_req/vid_addr, input, 1/ADDR_W: read-only video fetch request.
REQ-009 SHALL have ports vid_ack/vid_dout, output, 1/8: video completion pulse and read data.
REQ-010 SHALL have ports mem_read/mem_write/mem_refresh, output, 1 each: command strobes to the memory controller.
REQ-011 SHALL have ports mem_addr/mem_din, output, ADDR_W/8, and mem_dout/mem_busy, input, 8/1.
REQ-012 SHALL have port ready, output, 1: high once mem_busy has been sampled low after reset.

Function
REQ-013 SHALL use states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-014 In IDLE with mem_busy=0 and a winning request, SHALL pulse exactly one strobe for one cycle with mem_addr/mem_din valid that cycle, and go to WAIT_BUSY.
REQ-015 Arbitration: refresh if refresh_pending>=2; else video > CPU > refresh (pending>=1); fixed priority, no round-robin.
REQ-016 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle mem_busy=1.
REQ-017 In WAIT_DONE, on the first cycle mem_busy=0, SHALL register mem_dout into the served client's dout and pulse that client's ack in the next cycle; the state returns to IDLE on that same edge.
REQ-018 Latency: command cycle N, controller busy N+1..N+k, ack at cycle N+k+2.
REQ-019 A client's req SHALL be ignored in any cycle its ack is high (no double service); a client holds req/addr/din stable until ack.
REQ-020 CPU write: ack pulses as for read; cpu_dout SHALL be unchanged.
REQ-021 Refresh completion SHALL pulse no ack and decrement refresh_pending by 1.
REQ-022 Refresh timer counts only when ready=1; on reaching REFRESH_INTERVAL-1 it wraps to 0 and increments refresh_pending (2 bits, saturating at 3).
REQ-023 Timer wrap and refresh completion in the same cycle SHALL leave refresh_pending unchanged.
REQ-024 No command SHALL be issued while mem_busy=1, including during controller initialisation after reset.
REQ-025 Strobes SHALL be mutually exclusive and registered outputs.

Reset
REQ-026 reset SHALL force state IDLE and clear refresh_pending, timer, ready, all strobes, acks, mem_addr, mem_din, cpu_dout and vid_dout to 0.
REQ-027 Reset mid-transaction SHALL abandon it without an ack; the next command waits for mem_busy=0.

Structure
REQ-028 State encoding, client-id encoding and default ADDR_W SHALL live in shared package mem_arb_pkg.
REQ-029 The refresh interval counter and pending counter SHALL be sub-module refresh_timer.

Verification (controller BFM: busy high 4 cycles starting the cycle after a strobe, dout valid when busy falls)
REQ-030 Reset, BFM busy held high 100 cycles -> no strobe, ready=0; busy drops -> ready=1 next cycle.
REQ-031 CPU read addr 0x012345, BFM returns 0xA5 -> mem_read one cycle, cpu_ack one cycle at N+6, cpu_dout=0xA5.
REQ-032 cpu_req and vid_req raised in the same cycle -> video served first, CPU strobe in the first IDLE cycle after vid_ack; each ack exactly once.
REQ-033 REFRESH_INTERVAL=16, continuous vid_req -> pending reaches 2, refresh issued ahead of video, pending back to 1.
REQ-034 CPU write 0x3C to 0x000010 -> mem_write one cycle, mem_din=0x3C, cpu_ack pulses, cpu_dout unchanged.
REQ-035 reset asserted in WAIT_DONE -> no ack, all outputs 0, ready=0 next cycle.
